// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: state codes, opcodes,
// ALU/mux select codes, trap causes and a few decode helpers.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_ILLEGAL  = 2'd1,
        TRAP_MISALIGN = 2'd2,
        TRAP_TIMEOUT  = 2'd3
    } trap_cause_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_BLT  = 4'b1011;
    localparam logic [3:0] ALU_BGE  = 4'b1100;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    localparam logic [1:0] PCSRC_PC4    = 2'd0;
    localparam logic [1:0] PCSRC_ALU    = 2'd1;
    localparam logic [1:0] PCSRC_ALU_E  = 2'd2;
    localparam logic [1:0] PCSRC_BRANCH = 2'd3;

    localparam logic [1:0] RWSRC_PC4  = 2'd0;
    localparam logic [1:0] RWSRC_LOAD = 2'd1;
    localparam logic [1:0] RWSRC_ALU  = 2'd2;

    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_RA1  = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Sizes a load/store may name when sub-word accesses are decoded.
    function automatic logic subword_f3_ok(input logic is_store, input logic [2:0] f3);
        if (is_store) return (f3 <= 3'b010);
        return (f3 <= 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // funct3 010/011 are unused branch encodings.
    function automatic logic branch_f3_legal(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

    function automatic logic [3:0] branch_aluop(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_BEQ;
            3'b001:  return ALU_BNE;
            3'b100:  return ALU_BLT;
            3'b101:  return ALU_BGE;
            3'b110:  return ALU_BLTU;
            3'b111:  return ALU_BGEU;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_uctrl_if.sv
// Bundle of the control unit's datapath-facing signals. The controller view
// drives the enables and selects; the datapath view supplies the instruction,
// the address low bits and the memory completion strobe.
interface mc_uctrl_if;
    logic [31:0] INSTR;
    logic [1:0]  ADDR_LO;
    logic        MEM_RDY;
    logic [2:0]  uPC;
    logic [3:0]  ALUOp;
    logic [1:0]  ALUSrcA;
    logic        ALUSrcB;
    logic [1:0]  PCSrc;
    logic [1:0]  RWSrc;
    logic [3:0]  D_MEM_BE;
    logic [2:0]  LD_SIZE;
    logic        D_MEM_WEN;
    logic        RF_WE;
    logic        PCWrite;
    logic        isBranch;
    logic        MemRead;
    logic        IorD;
    logic        IRWrite;
    logic        ALUWrite;
    logic        INSTR_FINISH;
    logic [1:0]  TRAP_CAUSE;

    modport ctrl (
        input  INSTR, ADDR_LO, MEM_RDY,
        output uPC, ALUOp, ALUSrcA, ALUSrcB, PCSrc, RWSrc, D_MEM_BE, LD_SIZE,
               D_MEM_WEN, RF_WE, PCWrite, isBranch, MemRead, IorD, IRWrite,
               ALUWrite, INSTR_FINISH, TRAP_CAUSE
    );

    modport dp (
        output INSTR, ADDR_LO, MEM_RDY,
        input  uPC, ALUOp, ALUSrcA, ALUSrcB, PCSrc, RWSrc, D_MEM_BE, LD_SIZE,
               D_MEM_WEN, RF_WE, PCWrite, isBranch, MemRead, IorD, IRWrite,
               ALUWrite, INSTR_FINISH, TRAP_CAUSE
    );
endinterface

// File: rtl/mc_be_gen.sv
// Data byte-enable generator: maps the access size in funct3[1:0] and the
// address low bits to lane enables, and flags accesses that straddle lanes.
module mc_be_gen (
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] be_o,
    output logic       misaligned_o
);
    logic unused_sign;
    assign unused_sign = funct3_i[2];

    // Size decode: byte, half (even lanes only), word (lane 0 only).
    always_comb begin
        be_o         = 4'b0000;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: be_o = 4'b0001 << addr_lo_i;
            2'b01: begin
                be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                misaligned_o = addr_lo_i[0];
            end
            2'b10: begin
                be_o         = 4'b1111;
                misaligned_o = |addr_lo_i;
            end
            default: be_o = 4'b0000;
        endcase
    end
endmodule

// File: rtl/mc_uctrl.sv
// Multi-cycle RV32I control unit: IF/ID/EX/MEM/WB sequencer with wait-state
// timeout and an absorbing TRAP state. uPC exposes the current state.
module mc_uctrl
    import mc_pkg::*;
#(
    parameter int SUBWORD = 1,
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTR,
    input  logic [1:0]  ADDR_LO,
    input  logic        MEM_RDY,
    output logic [2:0]  uPC,
    output logic [3:0]  ALUOp,
    output logic [1:0]  ALUSrcA,
    output logic        ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic [1:0]  RWSrc,
    output logic [3:0]  D_MEM_BE,
    output logic [2:0]  LD_SIZE,
    output logic        D_MEM_WEN,
    output logic        RF_WE,
    output logic        PCWrite,
    output logic        isBranch,
    output logic        MemRead,
    output logic        IorD,
    output logic        IRWrite,
    output logic        ALUWrite,
    output logic        INSTR_FINISH,
    output logic [1:0]  TRAP_CAUSE
);
    // A TIMEOUT the counter cannot reach is treated as disabled.
    localparam bit                TMO_EN  = (TIMEOUT > 0) && (TIMEOUT < (1 << WAIT_W));
    localparam logic [WAIT_W-1:0] TMO_VAL = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    trap_cause_e       cause_q, cause_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       rdy, timeout_hit, is_load, is_store, ls_ok, misaligned;
    logic [3:0] be;
    logic       unused_instr;

    assign opcode       = INSTR[6:0];
    assign funct3       = INSTR[14:12];
    assign unused_instr = ^{INSTR[31], INSTR[29:15], INSTR[11:7]};
    // Memory completion is ignored while reset is held so reset outputs stay clean.
    assign rdy          = MEM_RDY & ~RST;
    assign is_load      = (opcode == OPC_LOAD);
    assign is_store     = (opcode == OPC_STORE);
    assign timeout_hit  = TMO_EN && (cnt_q == TMO_VAL) && !rdy;
    assign ls_ok        = !(is_load || is_store) ? 1'b1 :
                          (SUBWORD != 0) ? subword_f3_ok(is_store, funct3) :
                          (funct3 == 3'b010);
    assign uPC          = state_q;
    assign TRAP_CAUSE   = cause_q;

    mc_be_gen u_be_gen (
        .funct3_i    (funct3),
        .addr_lo_i   (ADDR_LO),
        .be_o        (be),
        .misaligned_o(misaligned)
    );

    // State, wait counter and first trap cause; reset lands in IF.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IF;
            cnt_q   <= '0;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Wait counter: counts stalled IF/MEM cycles, cleared on any other cycle.
    always_comb begin
        cnt_d = '0;
        if ((state_q == ST_IF || state_q == ST_MEM) && !rdy)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Next state and all control outputs, inactive unless the state sets them.
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        ALUOp        = ALU_ADD;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = 1'b0;
        PCSrc        = PCSRC_PC4;
        RWSrc        = RWSRC_PC4;
        D_MEM_BE     = 4'b0000;
        LD_SIZE      = 3'b000;
        D_MEM_WEN    = 1'b1;
        RF_WE        = 1'b0;
        PCWrite      = 1'b0;
        isBranch     = 1'b0;
        MemRead      = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        ALUWrite     = 1'b0;
        INSTR_FINISH = 1'b0;
        case (state_q)
            ST_IF: begin
                MemRead = 1'b1;
                if (rdy) begin
                    IRWrite = 1'b1;
                    state_d = ST_ID;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            ST_ID: begin
                if (opcode_legal(opcode) && ls_ok) begin
                    state_d = ST_EX;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end
            end
            ST_EX: begin
                ALUWrite = 1'b1;
                ALUSrcB  = 1'b1;
                state_d  = ST_WB;
                case (opcode)
                    OPC_LUI:            ALUSrcA = SRCA_ZERO;
                    OPC_AUIPC, OPC_JAL: ALUSrcA = SRCA_PC;
                    OPC_JALR:           ALUSrcA = SRCA_RA1;
                    OPC_LOAD, OPC_STORE: begin
                        ALUSrcA = SRCA_RA1;
                        state_d = ST_MEM;
                    end
                    // Register operand A for the arithmetic forms.
                    OPC_OPIMM: begin
                        ALUSrcA = SRCA_RA1;
                        ALUOp   = {(funct3 == 3'b101) & INSTR[30], funct3};
                    end
                    OPC_OP: begin
                        ALUSrcA = SRCA_RA1;
                        ALUSrcB = 1'b0;
                        ALUOp   = {INSTR[30], funct3};
                    end
                    OPC_BRANCH: begin
                        ALUSrcA = SRCA_PC;
                        if (branch_f3_legal(funct3)) begin
                            ALUOp        = branch_aluop(funct3);
                            PCSrc        = PCSRC_BRANCH;
                            isBranch     = 1'b1;
                            PCWrite      = 1'b1;
                            INSTR_FINISH = 1'b1;
                            state_d      = ST_IF;
                        end else begin
                            state_d = ST_TRAP;
                            cause_d = TRAP_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                // A misaligned address never reaches the bus.
                if (misaligned) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_MISALIGN;
                end else begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (is_store) begin
                        D_MEM_WEN = 1'b0;
                        D_MEM_BE  = be;
                    end
                    if (rdy) begin
                        if (is_store) begin
                            PCWrite      = 1'b1;
                            INSTR_FINISH = 1'b1;
                            state_d      = ST_IF;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (timeout_hit) begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_TIMEOUT;
                    end
                end
            end
            ST_WB: begin
                RF_WE        = 1'b1;
                PCWrite      = 1'b1;
                INSTR_FINISH = 1'b1;
                state_d      = ST_IF;
                case (opcode)
                    OPC_JAL:  PCSrc = PCSRC_ALU;
                    OPC_JALR: PCSrc = PCSRC_ALU_E;
                    OPC_LOAD: begin
                        RWSrc   = RWSRC_LOAD;
                        LD_SIZE = funct3;
                    end
                    default:  RWSrc = RWSRC_ALU;
                endcase
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IF;
        endcase
    end
endmodule

// File: doc/mc_uctrl.md
MC_UCTRL -- requirements
Module: mc_uctrl

Interface
REQ-001 SHALL have parameter SUBWORD, default 1, meaning LB/LH/LBU/LHU/SB/SH are decoded; if 0 they are illegal.
REQ-002 SHALL have parameter WAIT_W, default 4, meaning the width of the wait-state counter.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the number of stalled cycles before a trap; 0 disables the timeout.
REQ-004 SHALL have ports, in this order:
  - CLK  in  1  single clock; all state updates on the rising edge.
  - RST  in  1  reset; asynchronous, active-high.
  - INSTR  in  32  current instruction register contents.
  - ADDR_LO  in  2  ALU result [1:0]; data address alignment.
  - MEM_RDY  in  1  memory completed the current request this cycle.
  - uPC  out  3  state code: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=7.
  - ALUOp  out  4  ALU operation; same encoding as the existing ALU.
  - ALUSrcA  out  2  ALU A operand: 0 PC, 1 RA1, 2 zero.
  - ALUSrcB  out  1  ALU B operand: 0 RA2, 1 IMM.
  - PCSrc  out  2  PC source: 0 PC+4, 1 ALU, 2 ALU&~1, 3 branch-select.
  - RWSrc  out  2  RF write source: 0 PC+4, 1 load data, 2 ALU.
  - D_MEM_BE  out  4  data byte enables.
  - LD_SIZE  out  3  INSTR[14:12] for the load extender; valid in WB.
  - D_MEM_WEN  out  1  data write enable, active-low.
  - RF_WE  out  1  register-file write enable.
  - PCWrite  out  1  PC write enable.
  - isBranch  out  1  PC write is gated by the branch condition.
  - MemRead  out  1  memory request.
  - IorD  out  1  address select: 0 PC (instruction), 1 ALU (data).
  - IRWrite  out  1  instruction register load.
  - ALUWrite  out  1  ALU output register load.
  - INSTR_FINISH  out  1  last cycle of the instruction.
  - TRAP_CAUSE  out  2  trap cause: 0 none, 1 illegal, 2 misaligned, 3 timeout.

Function
REQ-005 SHALL hold the state in a register; all outputs SHALL be combinational from the state, INSTR, ADDR_LO and MEM_RDY.
REQ-006 In every state, any output not listed for that state SHALL be driven inactive: 0, with D_MEM_WEN=1.
REQ-007 IF: MemRead=1, IorD=0; stays in IF while MEM_RDY=0; IRWrite=1 and transition to ID in the cycle MEM_RDY=1.
REQ-008 ID: decode the opcode; a legal opcode goes to EX; otherwise go to TRAP with cause 1.
  - Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
REQ-009 EX: ALUWrite=1, ALUSrcB=1 and ALUOp=add unless an opcode rule below says otherwise.
  - LUI: ALUSrcA=2 (zero).
  - AUIPC and JAL: ALUSrcA=0 (PC).
  - JALR, LOAD, STORE: ALUSrcA=1 (RA1).
  - OP-IMM: ALUOp={funct3==101 & INSTR[30], funct3}.
  - OP: ALUSrcB=0, ALUOp={INSTR[30], funct3}.
REQ-010 BRANCH in EX SHALL finish the instruction in that cycle and return to IF.
  - Drives ALUSrcA=0, PCSrc=3, isBranch=1, PCWrite=1, INSTR_FINISH=1.
  - ALUOp by funct3: 000→1001, 001→1010, 100→1011, 101→1100, 110→1110, 111→1111.
  - Funct3 010 or 011 SHALL go to TRAP with cause 1.
REQ-011 EX next state: LOAD/STORE go to MEM; all other non-branch opcodes go to WB.
REQ-012 MEM: MemRead=1, IorD=1; stays in MEM until MEM_RDY=1.
REQ-013 STORE in MEM: D_MEM_WEN=0 with byte enables as below.
  - SW: BE=1111.
  - SH: BE=0011<<(2·ADDR_LO[1]).
  - SB: BE=0001<<ADDR_LO.
  - On MEM_RDY=1: PCWrite=1, PCSrc=0, INSTR_FINISH=1, then go to IF.
REQ-014 LOAD in MEM: on MEM_RDY=1 go to WB.
REQ-015 WB finishes every remaining instruction: RF_WE=1, PCWrite=1, INSTR_FINISH=1, then go to IF.
  - JAL: RWSrc=0, PCSrc=1.
  - JALR: RWSrc=0, PCSrc=2.
  - LOAD: RWSrc=1, PCSrc=0.
  - All others: RWSrc=2, PCSrc=0.
REQ-016 Misalignment SHALL be detected on MEM entry and SHALL go to TRAP with cause 2; no write is issued.
  - Word access with ADDR_LO≠00.
  - Half access with ADDR_LO[0]=1.
REQ-017 With SUBWORD=0, any LOAD/STORE whose funct3 is not 010 SHALL trap with cause 1 in ID.
REQ-018 Wait-state counter:
  - Cleared on entry to IF or MEM.
  - Increments each cycle spent in IF or MEM with MEM_RDY=0; saturates.
  - When count==TIMEOUT and MEM_RDY=0 (TIMEOUT≠0), go to TRAP with cause 3.
  - If MEM_RDY=1 in that same cycle, MEM_RDY wins and there is no trap.
REQ-019 TRAP SHALL be absorbing until reset; all enables inactive; TRAP_CAUSE holds the first cause.
REQ-020 Each instruction SHALL assert INSTR_FINISH exactly once, and PCWrite only in the INSTR_FINISH cycle.
REQ-021 Latency with zero wait states SHALL be: branch 3 cycles, ALU/jump/LUI/AUIPC 4, store 4, load 5.

Reset
REQ-022 RST=1 SHALL asynchronously force the following, regardless of current state, including mid-MEM with D_MEM_WEN=0:
  - state=IF, counter=0, TRAP_CAUSE=0.
  - Outputs: MemRead=1, IorD=0, D_MEM_WEN=1, all other enables 0.
REQ-023 The first fetch SHALL begin on the first rising edge after RST deasserts.

Structure
REQ-024 State codes, opcode constants, ALUOp codes, PCSrc/RWSrc/ALUSrcA codes and trap causes SHALL live in the shared package mc_pkg.
REQ-025 One sub-module, mc_be_gen, SHALL compute D_MEM_BE and the misalignment flag from funct3 and ADDR_LO.

Verification
REQ-026 ADD x3,x1,x2 (0x002081B3) with MEM_RDY held 1 → uPC 0,1,2,4; in EX ALUOp=0000, ALUSrcB=0; in WB RF_WE=1, RWSrc=2, PCWrite=1.
REQ-027 SB with ADDR_LO=10, MEM_RDY low 3 cycles in MEM → BE=0100 and D_MEM_WEN=0 for 4 cycles; INSTR_FINISH only on the 4th.
REQ-028 BNE (funct3 001) → EX drives ALUOp=1010, PCSrc=3, isBranch=1, PCWrite=1; next state IF; 3 cycles total.
REQ-029 LW with ADDR_LO=01 → MEM entry goes to TRAP, TRAP_CAUSE=2, no D_MEM_WEN=0 pulse; RST recovers to IF.
REQ-030 MEM_RDY stuck 0 in IF, TIMEOUT=15 → TRAP with cause 3 after 16 IF cycles; a separate run raising MEM_RDY on cycle 16 → ID, no trap.
REQ-031 Opcode 0x7F → TRAP cause 1 from ID; RST asserted mid-cycle → outputs return to reset values immediately, with no clock edge.
